// File: rtl/agc_time_pulse_gen.sv
// Purpose: AGC time-pulse generator; sequences STBY/PWRON/TP1..TP12/SRLSE/WAIT and decodes a one-hot TP bus.
// Latency: state moves on CLK1-qualified edges; TP bus follows on the next CLK2-only edge; TP12_STRB/MCT_CNT on the TP12 exit edge.
// Backpressure: none; RUN=0 parks at SRLSE until STEP, and STBY_REQ is honoured only outside TP1..TP11.
// Optional: AGC_TPG_STEP_DEBOUNCE_EN adds a 2-flop synchroniser plus DB_CYC-cycle debounce on STEP.
module agc_time_pulse_gen #(
   parameter int CNT_W     = 16,
   parameter int PWRON_CYC = 4,
   parameter int DB_CYC    = 8
) (
   input  logic             CK_CLK,
   input  logic             NPURST,
   input  logic             CLK1,
   input  logic             CLK2,
   input  logic             STBY_REQ,
   input  logic             RUN,
   input  logic             STEP,
   output logic [3:0]       TPG,
   output logic [15:0]      TP,
   output logic             TP12_STRB,
   output logic [CNT_W-1:0] MCT_CNT
);

   typedef enum logic [3:0] {
      ST_STBY  = 4'd0,
      ST_PWRON = 4'd1,
      ST_TP1   = 4'd2,
      ST_TP12  = 4'd13,
      ST_SRLSE = 4'd14,
      ST_WAIT  = 4'd15
   } state_t;

   localparam logic [3:0] PWRON_LAST = 4'(PWRON_CYC - 1);

   // Reject configurations the 4-bit hold counter or the debouncer cannot honour.
   if (PWRON_CYC < 1 || PWRON_CYC > 15 || DB_CYC < 1) begin : g_bad_param
      $error("agc_time_pulse_gen: PWRON_CYC must be 1..15 and DB_CYC >= 1");
   end

   state_t             r_state;
   logic [3:0]         r_hold;
   logic [15:0]        r_tp;
   logic               r_strb;
   logic [CNT_W-1:0]   r_mct;
   logic               w_step;

`ifdef AGC_TPG_STEP_DEBOUNCE_EN
   localparam int DB_W = $clog2(DB_CYC + 1);

   logic [1:0]         r_step_sync;
   logic [DB_W-1:0]    r_db_cnt;
   logic               r_step_db;

   // Bring the panel STEP level into the CK_CLK domain.
   always_ff @(posedge CK_CLK or negedge NPURST) begin
      if (!NPURST) r_step_sync <= 2'b00;
      else         r_step_sync <= {r_step_sync[0], STEP};
   end

   // Accept a new STEP level only after DB_CYC consecutive cycles of disagreement.
   always_ff @(posedge CK_CLK or negedge NPURST) begin
      if (!NPURST) begin
         r_db_cnt  <= '0;
         r_step_db <= 1'b0;
      end else if (r_step_sync[1] == r_step_db) begin
         r_db_cnt  <= '0;
      end else if (r_db_cnt == DB_W'(DB_CYC - 1)) begin
         r_db_cnt  <= '0;
         r_step_db <= r_step_sync[1];
      end else begin
         r_db_cnt  <= r_db_cnt + 1'b1;
      end
   end

   assign w_step = r_step_db;
`else
   assign w_step = STEP;
`endif

   // Ring sequencer: advances only on CLK1 edges; TP12 exit pulses the strobe and counts the cycle.
   always_ff @(posedge CK_CLK or negedge NPURST) begin
      if (!NPURST) begin
         r_state <= ST_STBY;
         r_hold  <= '0;
         r_strb  <= 1'b0;
         r_mct   <= '0;
      end else begin
         r_strb <= 1'b0;
         if (CLK1) begin
            case (r_state)
               ST_STBY: begin
                  if (!STBY_REQ) begin
                     r_state <= ST_PWRON;
                     r_hold  <= '0;
                  end
               end
               ST_PWRON: begin
                  if (STBY_REQ) begin
                     r_state <= ST_STBY;
                  end else begin
                     r_hold <= r_hold + 4'd1;
                     if (r_hold == PWRON_LAST) r_state <= ST_TP1;
                  end
               end
               ST_TP12: begin
                  r_strb <= 1'b1;
                  r_mct  <= r_mct + 1'b1;
                  if (STBY_REQ)  r_state <= ST_STBY;
                  else if (RUN)  r_state <= ST_TP1;
                  else           r_state <= ST_SRLSE;
               end
               ST_SRLSE: begin
                  if (STBY_REQ)    r_state <= ST_STBY;
                  else if (RUN)    r_state <= ST_TP1;
                  else if (w_step) r_state <= ST_WAIT;
               end
               ST_WAIT: begin
                  if (STBY_REQ)     r_state <= ST_STBY;
                  else if (!w_step) r_state <= ST_TP1;
               end
               // TP1..TP11 always step forward so an instruction is never cut short.
               default: r_state <= state_t'(r_state + 4'd1);
            endcase
         end
      end
   end

   // TP bus reloads from the state on CLK2-only edges, one phase behind TPG.
   always_ff @(posedge CK_CLK or negedge NPURST) begin
      if (!NPURST)          r_tp <= 16'h0001;
      else if (CLK2 && !CLK1) r_tp <= 16'h0001 << r_state;
   end

   assign TPG       = r_state;
   assign TP        = r_tp;
   assign TP12_STRB = r_strb;
   assign MCT_CNT   = r_mct;

endmodule
